sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port round-robin arbiter that shares the single 32-bit SRAM controller between two requesters, e.g. the data-memory stage (port 0) and a write-back/DMA path (port 1). It accepts one request at a time and issues a one-cycle `wr_en`/`rd_en` pulse to the controller. It waits for the controller's `ready`, then returns a registered `done` pulse and read data to the owning port. It sits between the pipeline's memory clients and the SRAM controller, in the same clock domain.

## Interface
- `ADDR_W`, default 32: request address width; passed unchanged to the controller.
- `DATA_W`, default 32: data width, matching the controller's word.
- `clk` input 1: the single clock. All logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `p0_req`, `p1_req` input 1: request valid; held until the matching `gnt`.
- `p0_we`, `p1_we` input 1: 1 = write, 0 = read. Qualified by `req`.
- `p0_addr`, `p1_addr` input ADDR_W: byte address.
- `p0_wdata`, `p1_wdata` input DATA_W: write data.
- `p0_gnt`, `p1_gnt` output 1: combinational accept pulse, high in the cycle the request is latched.
- `p0_done`, `p1_done` output 1: registered one-cycle completion pulse.
- `rdata` output DATA_W: last completed read data, shared by both ports. Valid with `done` and held until the next read completes.
- `mem_wr_en`, `mem_rd_en` output 1: to the controller; one-cycle pulses.
- `mem_address` output ADDR_W, `mem_writeData` output DATA_W: to the controller, driven from the latched request.
- `mem_readData` input DATA_W, `mem_ready` input 1: from the controller.
- `busy` output 1: arbiter is not in IDLE.
- `owner` output 1: port of the current or last transaction.

## Operation
- FSM states are IDLE, ISSUE and WAIT.
- IDLE:
  - When any `req` is high, choose the winner, assert its `gnt`, latch `we`/`addr`/`wdata`/`owner`, and go to ISSUE.
  - Stay in IDLE otherwise.
- ISSUE:
  - Assert `mem_wr_en` if the latched `we` is 1, else `mem_rd_en`, for exactly this cycle.
  - Go to WAIT unconditionally.
  - `mem_ready` is ignored in ISSUE, because the controller still reports idle in that cycle.
- WAIT:
  - Both enables stay low.
  - On `mem_ready`=1: pulse `pN_done` for `owner` in the next cycle. For reads, also register `rdata <= mem_readData`. Then go to IDLE.
  - Otherwise stay in WAIT. There is no timeout.
- Round-robin rule:
  - If both ports request, the port not equal to `last_owner` wins.
  - A single requester always wins.
  - `last_owner` updates on every grant.
- `mem_address`/`mem_writeData` are stable from ISSUE through the end of WAIT.
- Requesters must not raise a new `req` before their `done`. A `req` that arrives during ISSUE/WAIT simply waits; it is never dropped.
- Writes leave `rdata` unchanged.

## Timing
- Reset values:
  - state = IDLE, `last_owner` = 1 (so port 0 wins first), `owner` = 0.
  - `rdata` = 0, all `gnt`/`done` = 0, `mem_wr_en` = `mem_rd_en` = 0, `busy` = 0, latched address and data = 0.
- Reset mid-transaction returns the arbiter to IDLE immediately with no `done`. The controller's reset is driven from the same source (`~rst_n`), so both sides restart idle.
- Read, with the grant in cycle 0:
  - ISSUE in cycle 1, WAIT in cycles 2-6.
  - `mem_ready` goes high in cycle 6.
  - `done` and valid `rdata` appear in cycle 7.
- Write, with the grant in cycle 0:
  - ISSUE in cycle 1, `mem_ready` in cycle 3, `done` in cycle 4.
- Back-to-back: the `done` cycle is an IDLE cycle and can grant the next request, so there is zero dead cycles between transactions.
- Simultaneous `done` for one port and `req` from the other is legal, and the new request is granted in that cycle.

## Structure
- `sram_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT);
  - `NUM_PORTS` = 2;
  - `RD_LAT` = 7 and `WR_LAT` = 4, for bench checking.
- One sub-module, `rr_pick2`: combinational two-way round-robin selector. Inputs are `req[1:0]` and `last_owner`; outputs are `winner` and `valid`.

## Test plan
- Reset release, then a port-0 read of 0x0000_0010 while the controller model returns 0xDEAD_BEEF: `p0_gnt` in cycle 0, one `mem_rd_en` pulse in cycle 1, `p0_done` and `rdata` = 0xDEAD_BEEF in cycle 7.
- Port-1 write of 0x1234_5678 to 0x0000_0020: one `mem_wr_en` pulse, `mem_writeData` = 0x1234_5678 stable through WAIT, `p1_done` in cycle 4, `rdata` unchanged.
- Both ports request reads in the same cycle after reset: port 0 is granted first, port 1 in the `p0_done` cycle, `p1_done` 7 cycles later.
- Both ports hold `req` continuously for 6 transactions: grants alternate 0,1,0,1,0,1 with no idle gap cycles.
- `rst_n` asserted in cycle 3 of a read: no `done` at any point, all outputs return to their reset values asynchronously, and the next request completes normally.
- `p1_req` raised during port 0's WAIT: it is not granted until the `p0_done` cycle, and `mem_*_en` never pulses twice within one transaction.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared definitions for the two-port SRAM arbiter: the arbiter FSM
//   state encoding, the port count, and the end-to-end latencies
//   (grant cycle to done cycle) seen with the reference controller.
//   No ports; imported by rr_pick2 and sram_arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam int NUM_PORTS = 2;

  // Grant-to-done distances in cycles for a read and for a write.
  localparam int RD_LAT = 7;
  localparam int WR_LAT = 4;

endpackage

// File: rtl/sram_arbiter_rr_pick2.sv
// rr_pick2
//   Combinational two-way round-robin selector.
//   Ports:
//     req        in  [NUM_PORTS-1:0] request vector (bit N = port N)
//     last_owner in  1  port that received the previous grant
//     winner     out 1  selected port (only meaningful when valid)
//     valid      out 1  at least one request is present
module rr_pick2
  import sram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last_owner,
  output logic                 winner,
  output logic                 valid
);

  // A lone requester always wins; on a tie the port that did not
  // own the previous transaction goes next.
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_owner;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one SRAM controller between two requesters. One request is
//   accepted at a time, a single wr_en/rd_en pulse is issued, and after
//   the controller reports ready a registered done pulse (plus read data
//   for reads) is returned to the port that owns the transaction.
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     p0_*/p1_* req,we,addr,wdata request side of each port
//     p0_gnt, p1_gnt              combinational accept (request latched)
//     p0_done, p1_done            registered one-cycle completion
//     rdata                       last completed read data (shared)
//     mem_wr_en, mem_rd_en        one-cycle command pulses to controller
//     mem_address, mem_writeData  latched request toward controller
//     mem_readData, mem_ready     response from controller
//     busy                        FSM not in IDLE
//     owner                       port of current or last transaction
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_done,
  output logic              p1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  input  logic [DATA_W-1:0] mem_readData,
  input  logic              mem_ready,
  output logic              busy,
  output logic              owner
);

  arb_state_t        state_q, state_d;
  logic              last_owner_q;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        done_q;
  logic              winner;
  logic              pick_valid;
  logic              grant;
  logic              complete;

  rr_pick2 u_pick (
    .req       ({p1_req, p0_req}),
    .last_owner(last_owner_q),
    .winner    (winner),
    .valid     (pick_valid)
  );

  // A grant can only happen from IDLE; that includes the done cycle,
  // which is what gives back-to-back transactions without a gap.
  assign grant    = (state_q == IDLE) && pick_valid;
  assign complete = (state_q == WAIT) && mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // mem_ready is deliberately ignored in ISSUE: the controller has not
  // seen the command yet and still reports its idle ready state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        p0_gnt = grant & ~winner;
        p1_gnt = grant &  winner;
      end
      ISSUE: begin
        mem_wr_en =  we_q;
        mem_rd_en = ~we_q;
      end
      default: ;
    endcase
  end

  // Request capture on grant; the latched copy drives the controller
  // so address/data stay stable even after the requester drops req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else if (grant) begin
      last_owner_q <= winner;
      owner_q      <= winner;
      we_q         <= winner ? p1_we    : p0_we;
      addr_q       <= winner ? p1_addr  : p0_addr;
      wdata_q      <= winner ? p1_wdata : p0_wdata;
    end
  end

  // Completion: done is registered so it lands in the cycle after
  // mem_ready; only reads update the shared read-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= 2'b00;
      rdata_q <= '0;
    end else begin
      done_q <= complete ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
      if (complete && !we_q) rdata_q <= mem_readData;
    end
  end

  assign p0_done       = done_q[0];
  assign p1_done       = done_q[1];
  assign rdata         = rdata_q;
  assign mem_address   = addr_q;
  assign mem_writeData = wdata_q;
  assign busy          = (state_q != IDLE);
  assign owner         = owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Self-checking bench for sram_arbiter. Transactions are queued per
//   port and, in expected grant order, on a scoreboard; a negedge
//   monitor pops the scoreboard on each grant and checks ordering,
//   command pulses, latency and read data on each done.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    bit          b2b;
  } txn_t;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_done, p1_done;
  logic [31:0] rdata;
  logic        mem_wr_en, mem_rd_en;
  logic [31:0] mem_address, mem_writeData, mem_readData;
  logic        mem_ready;
  logic        busy, owner;

  txn_t        exp_q[$];
  txn_t        q0[$];
  txn_t        q1[$];
  int          check_count = 0;
  int          pass_count  = 0;
  logic [31:0] last_rd     = 0;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
    .rdata(rdata), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_readData(mem_readData), .mem_ready(mem_ready),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents the controller model returns for a read of a given address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Controller model: ready shows up 5 cycles after a read command and
  // 2 cycles after a write command; writes load junk into readData.
  logic [2:0]  mdl_cnt;
  logic [31:0] mdl_rdata;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_cnt   <= 3'd0;
      mdl_rdata <= 32'd0;
    end else if (mem_rd_en) begin
      mdl_cnt   <= 3'd5;
      mdl_rdata <= memfn(mem_address);
    end else if (mem_wr_en) begin
      mdl_cnt   <= 3'd2;
      mdl_rdata <= 32'hBAD0_0000 ^ mem_writeData;
    end else if (mdl_cnt != 3'd0) begin
      mdl_cnt <= mdl_cnt - 3'd1;
    end
  end
  assign mem_ready    = (mdl_cnt == 3'd1);
  assign mem_readData = mdl_rdata;

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Queue one transaction for a port and its expected outcome on the
  // scoreboard; calls must be made in expected grant order.
  task automatic applyStimulus(input bit port, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input int delay, input bit b2b);
    txn_t t;
    t.port = port; t.we = we; t.addr = addr; t.wdata = wdata;
    t.delay = delay; t.b2b = b2b;
    if (!we) last_rd = memfn(addr);
    t.rdata = last_rd;
    exp_q.push_back(t);
    if (port) q1.push_back(t);
    else      q0.push_back(t);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"},  64'(busy), 64'd0);
    checkOutput({tag, "_done"},  64'({p1_done, p0_done}), 64'd0);
    checkOutput({tag, "_gnt"},   64'({p1_gnt, p0_gnt}), 64'd0);
    checkOutput({tag, "_en"},    64'({mem_wr_en, mem_rd_en}), 64'd0);
    checkOutput({tag, "_owner"}, 64'(owner), 64'd0);
    checkOutput({tag, "_rdata"}, 64'(rdata), 64'd0);
    checkOutput({tag, "_addr"},  64'(mem_address), 64'd0);
    checkOutput({tag, "_wdata"}, 64'(mem_writeData), 64'd0);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 || busy ||
            p0_req || p1_req) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) checkOutput({tag, "_idle_timeout"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Port 0 requester: raise req, hold until gnt, then wait for done
  // (or a reset) before taking the next queued transaction.
  initial begin : drv0
    txn_t t;
    int   n;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    forever begin
      @(posedge clk); #1;
      if (q0.size() != 0) begin
        t = q0.pop_front();
        if (t.delay > 0) begin repeat (t.delay) @(posedge clk); #1; end
        p0_we = t.we; p0_addr = t.addr; p0_wdata = t.wdata; p0_req = 1;
        n = 0;
        @(negedge clk);
        while (!p0_gnt && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        p0_req = 0;
        n = 0;
        while (!p0_done && rst_n && n < 200) begin @(negedge clk); n++; end
      end
    end
  end

  // Port 1 requester, same protocol as port 0.
  initial begin : drv1
    txn_t t;
    int   n;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    forever begin
      @(posedge clk); #1;
      if (q1.size() != 0) begin
        t = q1.pop_front();
        if (t.delay > 0) begin repeat (t.delay) @(posedge clk); #1; end
        p1_we = t.we; p1_addr = t.addr; p1_wdata = t.wdata; p1_req = 1;
        n = 0;
        @(negedge clk);
        while (!p1_gnt && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        p1_req = 0;
        n = 0;
        while (!p1_done && rst_n && n < 200) begin @(negedge clk); n++; end
      end
    end
  end

  // Monitor: completion is handled before grant so a grant in the done
  // cycle sees the previous transaction already retired.
  txn_t cur;
  bit   in_flight = 0;
  int   cyc = 0, gcyc = 0, last_done = -100, pulses = 0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_flight = 0;
      pulses    = 0;
    end else begin
      if (p0_done || p1_done) begin
        if (!in_flight) begin
          checkOutput("stray_done", 64'({p1_done, p0_done}), 64'd0);
        end else begin
          checkOutput("done_port", 64'({p1_done, p0_done}), cur.port ? 64'd2 : 64'd1);
          checkOutput("owner", 64'(owner), 64'(cur.port));
          checkOutput("latency", 64'(cyc - gcyc), cur.we ? 64'(WR_LAT) : 64'(RD_LAT));
          checkOutput("rdata", 64'(rdata), 64'(cur.rdata));
          checkOutput("en_pulses", 64'(pulses), 64'd1);
          in_flight = 0;
          last_done = cyc;
        end
      end
      if (p0_gnt || p1_gnt) begin
        if (exp_q.size() == 0) begin
          checkOutput("stray_gnt", 64'({p1_gnt, p0_gnt}), 64'd0);
        end else begin
          cur = exp_q.pop_front();
          checkOutput("gnt_port", 64'({p1_gnt, p0_gnt}), cur.port ? 64'd2 : 64'd1);
          checkOutput("gnt_while_busy", 64'(in_flight), 64'd0);
          if (cur.b2b) checkOutput("gnt_gap", 64'(cyc - last_done), 64'd0);
          in_flight = 1;
          gcyc      = cyc;
          pulses    = 0;
        end
      end
      if (mem_wr_en || mem_rd_en) begin
        if (!in_flight) begin
          checkOutput("stray_en", 64'({mem_wr_en, mem_rd_en}), 64'd0);
        end else begin
          pulses++;
          checkOutput("en_cycle", 64'(cyc - gcyc), 64'd1);
          checkOutput("en_kind", 64'({mem_wr_en, mem_rd_en}), cur.we ? 64'd2 : 64'd1);
          checkOutput("issue_addr", 64'(mem_address), 64'(cur.addr));
        end
      end
      if (mem_ready && in_flight && busy) begin
        checkOutput("wait_addr", 64'(mem_address), 64'(cur.addr));
        if (cur.we) checkOutput("wait_wdata", 64'(mem_writeData), 64'(cur.wdata));
      end
    end
  end

  initial begin : main
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues("por");
    rst_n = 1'b1;

    $display("[TB] port-0 read of 0x10");
    applyStimulus(0, 0, 32'h0000_0010, 32'h0, 0, 0);
    waitIdle("t1");

    $display("[TB] port-1 write to 0x20");
    applyStimulus(1, 1, 32'h0000_0020, 32'h1234_5678, 0, 0);
    waitIdle("t2");
    checkOutput("rdata_after_write", 64'(rdata), 64'h0000_0000_DEAD_BEEF);

    $display("[TB] simultaneous reads after reset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetValues("rst2");
    last_rd = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 32'h0000_0100, 32'h0, 0, 0);
    applyStimulus(1, 0, 32'h0000_0104, 32'h0, 0, 1);
    waitIdle("t3");

    $display("[TB] six back-to-back alternating transactions");
    for (int i = 0; i < 6; i++)
      applyStimulus(i[0], (i % 3) == 2, 32'h0000_0200 + 32'(i * 4),
                    32'hC0DE_0000 + 32'(i), 0, i != 0);
    waitIdle("t4");

    $display("[TB] reset in cycle 3 of a read");
    applyStimulus(0, 0, 32'h0000_0300, 32'h0, 0, 0);
    n = 0;
    @(negedge clk);
    while (!p0_gnt && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) checkOutput("t5_gnt_timeout", 64'(p0_gnt), 64'd1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("mid_rst");
    last_rd = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitIdle("t5a");
    applyStimulus(1, 0, 32'h0000_0304, 32'h0, 0, 0);
    waitIdle("t5b");

    $display("[TB] port-1 request raised during port-0 WAIT");
    applyStimulus(0, 0, 32'h0000_0400, 32'h0, 0, 0);
    applyStimulus(1, 1, 32'h0000_0404, 32'hFEED_F00D, 3, 1);
    waitIdle("t6");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
